lanectrl_pause_sync_array: RTL

Multi-lane pause conditioner for the DDR PHY lane controllers. It synchronises per-lane HS_IO_CLK pause requests into CLK with a configurable synchroniser depth. Each lane's pause is stretched to a minimum width, and a minimum low gap is enforced between pauses, so the lane control block never sees a runt pause or a runt release. It sits between the training/DFI pause sources and the NUM_LANES lane controller pause inputs, with an optional falling-edge output stage.

---
 rtl/lanectrl_pause_pkg.sv | 41 ++++
 rtl/lanectrl_pause_sync_array_if.sv | 17 +
 rtl/lanectrl_pause_lane.sv | 121 ++++++++++++
 rtl/lanectrl_pause_sync_array.sv | 66 ++++++
 4 files changed

// File: rtl/lanectrl_pause_pkg.sv
// Shared definitions for the lane pause conditioner.
//   pause_state_t : per-lane FSM state
//   range limits  : legal parameter ranges for the array and its lanes
//   cnt_width()   : width of the per-lane down-counter
package lanectrl_pause_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StHold,
    StGap
  } pause_state_t;

  localparam int unsigned MinLanes      = 1;
  localparam int unsigned MaxLanes      = 16;
  localparam int unsigned MinSyncStages = 1;
  localparam int unsigned MaxSyncStages = 4;
  localparam int unsigned MinPulseLo    = 1;
  localparam int unsigned MinPulseHi    = 15;
  localparam int unsigned MinGapHi      = 15;

  // Wide enough to hold max(min_pulse, min_gap); never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned min_pulse,
                                            input int unsigned min_gap);
    int unsigned m;
    m = (min_pulse > min_gap) ? min_pulse : min_gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int unsigned num_lanes,
                                   input int unsigned sync_stages,
                                   input int unsigned min_pulse,
                                   input int unsigned min_gap,
                                   input int unsigned fall_edge_out);
    return (num_lanes >= MinLanes) && (num_lanes <= MaxLanes) &&
           (sync_stages >= MinSyncStages) && (sync_stages <= MaxSyncStages) &&
           (min_pulse >= MinPulseLo) && (min_pulse <= MinPulseHi) &&
           (min_gap <= MinGapHi) && (fall_edge_out <= 1);
  endfunction

endpackage

// File: rtl/lanectrl_pause_sync_array_if.sv
// Pause bus between the pause sources and the lane controllers.
//   pause_req  : per-lane requests, asynchronous to CLK
//   pause_sync : conditioned per-lane pause
//   pause_any  : registered OR of all lane pause bits
//   stretched  : per-lane one-cycle strobe on an extended or deferred pause
// master = request source / consumer side, slave = conditioner.
interface lanectrl_pause_sync_array_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic [NUM_LANES-1:0] pause_req;
  logic [NUM_LANES-1:0] pause_sync;
  logic                 pause_any;
  logic [NUM_LANES-1:0] stretched;

  modport master (output pause_req, input pause_sync, input pause_any, input stretched);
  modport slave  (input pause_req, output pause_sync, output pause_any, output stretched);
endinterface

// File: rtl/lanectrl_pause_lane.sv
// One lane: request synchroniser, pause FSM and shared pulse/gap down-counter.
//   CLK, RESET    : lane control clock, asynchronous active-high reset
//   pause_req_i   : raw request, asynchronous to CLK
//   pause_o       : conditioned pause (registered)
//   stretched_o   : one-cycle strobe when a pause was extended or a request deferred
module lanectrl_pause_lane
  import lanectrl_pause_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = 2,
  parameter int unsigned MIN_GAP     = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pause_req_i,
  output logic pause_o,
  output logic stretched_o
);

  localparam int unsigned CntW = cnt_width(MIN_PULSE, MIN_GAP);
  localparam logic [CntW-1:0] PulseLoad = CntW'(MIN_PULSE - 1);
  localparam logic [CntW-1:0] GapLoad   = (MIN_GAP == 0) ? '0 : CntW'(MIN_GAP - 1);

  (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] sync_q;
  logic req_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pause_req_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  pause_state_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fell_q, fell_d;     // request dropped while the minimum width was running
  logic            pause_q, pause_d;
  logic            strb_q, strb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fell_d  = fell_q;
    strb_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          state_d = StAssert;
          cnt_d   = PulseLoad;
          fell_d  = 1'b0;
        end
      end
      StAssert: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          if (!req_s) fell_d = 1'b1;
        end else if (req_s) begin
          state_d = StHold;
        end else begin
          strb_d = fell_q;
          if (MIN_GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end
      end
      StHold: begin
        if (!req_s) begin
          if (MIN_GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end
      end
      StGap: begin
        // Requests are ignored until the gap expires; one still present then
        // is launched late and flagged.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (req_s) begin
          state_d = StAssert;
          cnt_d   = PulseLoad;
          fell_d  = 1'b0;
          strb_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    pause_d = (state_d == StAssert) || (state_d == StHold);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fell_q  <= 1'b0;
      pause_q <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fell_q  <= fell_d;
      pause_q <= pause_d;
      strb_q  <= strb_d;
    end
  end

  assign pause_o     = pause_q;
  assign stretched_o = strb_q;

endmodule

// File: rtl/lanectrl_pause_sync_array.sv
// Multi-lane pause conditioner for the DDR PHY lane controllers.
//   CLK, RESET : lane control clock, asynchronous active-high reset
//   pause_io   : pause bus (slave side): requests in, conditioned pause,
//                PAUSE_ANY and STRETCHED strobes out
// Each lane is independent; PAUSE_ANY is a registered OR of the lane pause bits.
// With FALL_EDGE_OUT=1 only pause_sync is retimed onto the falling edge.
module lanectrl_pause_sync_array
  import lanectrl_pause_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned MIN_PULSE     = 2,
  parameter int unsigned MIN_GAP       = 1,
  parameter int unsigned FALL_EDGE_OUT = 0
) (
  input logic                        CLK,
  input logic                        RESET,
  lanectrl_pause_sync_array_if.slave pause_io
);

  localparam bit ParamsOk = params_ok(NUM_LANES, SYNC_STAGES, MIN_PULSE, MIN_GAP, FALL_EDGE_OUT);

  logic [NUM_LANES-1:0] lane_pause;
  logic [NUM_LANES-1:0] lane_stretched;
  logic                 pause_any_q;

  if (ParamsOk) begin : g_lanes
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lanectrl_pause_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PULSE   (MIN_PULSE),
        .MIN_GAP     (MIN_GAP)
      ) u_lane (
        .CLK         (CLK),
        .RESET       (RESET),
        .pause_req_i (pause_io.pause_req[i]),
        .pause_o     (lane_pause[i]),
        .stretched_o (lane_stretched[i])
      );
    end
  end else begin : g_bad_params
    // Out-of-range configuration elaborates to a block that never pauses.
    assign lane_pause     = '0;
    assign lane_stretched = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pause_any_q <= 1'b0;
    else       pause_any_q <= |lane_pause;
  end

  if (FALL_EDGE_OUT != 0) begin : g_fall_out
    logic [NUM_LANES-1:0] pause_fe_q;
    always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) pause_fe_q <= '0;
      else       pause_fe_q <= lane_pause;
    end
    assign pause_io.pause_sync = pause_fe_q;
  end else begin : g_rise_out
    assign pause_io.pause_sync = lane_pause;
  end

  assign pause_io.pause_any = pause_any_q;
  assign pause_io.stretched = lane_stretched;

endmodule
